// File: rtl/pool_pkg.sv
// pool_pkg: shared helpers for the pooling stages.
//   pool_fn#(W)::smax(a, b) - signed maximum of two W-bit two's complement values
//   outlen(len, k)          - number of pooled outputs for a frame of len samples
//                             with non-overlapping windows of k (last window may be partial)
package pool_pkg;

  // Wrapped in a parameterized class so the same max helper can be reused at
  // any sample width by later pooling variants.
  virtual class pool_fn #(parameter int W = 8);
    static function logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
      return (a > b) ? a : b;
    endfunction
  endclass

  function automatic int outlen(input int len, input int k);
    return (len + k - 1) / k;
  endfunction

endpackage

// File: rtl/stream_maxpool.sv
// stream_maxpool: 1-D max pooling over a valid/ready sample stream.
// Each frame of LEN signed samples is split into non-overlapping windows of K
// samples; the signed maximum of each window is emitted on a registered
// valid/ready output. A short final window (LEN mod K != 0) emits the max of
// the samples it holds.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   s_data_in        signed input sample (WIDTH)
//   s_valid/s_ready  input handshake
//   m_data_out       signed pooled maximum (WIDTH)
//   m_valid/m_ready  output handshake
//   frame_done       one-cycle pulse after the last sample of a frame is accepted
module stream_maxpool
  import pool_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LEN    = 5,
  parameter int K      = 2,
  parameter int LOGLEN = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] m_data_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    frame_done
);

  localparam logic [LOGLEN-1:0] W_LAST = LOGLEN'(K - 1);
  localparam logic [LOGLEN-1:0] I_LAST = LOGLEN'(LEN - 1);

  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] out_reg;
  logic signed [WIDTH-1:0] cand;
  logic [LOGLEN-1:0]       wcnt;
  logic [LOGLEN-1:0]       idx;
  logic                    acc_in;
  logic                    last_in_frame;
  logic                    win_close;

  // A sample can only be taken when the output slot is free or being drained
  // this cycle, so a closing sample never overwrites an unconsumed result.
  assign s_ready       = !reset && (!m_valid || m_ready);
  assign acc_in        = s_valid && s_ready;
  assign last_in_frame = (idx == I_LAST);
  assign win_close     = (wcnt == W_LAST) || last_in_frame;

  // First sample of a window replaces the stale running max.
  assign cand = (wcnt == '0) ? s_data_in : pool_fn#(WIDTH)::smax(acc, s_data_in);

  assign m_data_out = out_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      out_reg    <= '0;
      m_valid    <= 1'b0;
      wcnt       <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc_in && last_in_frame;

      // A load wins over a drain: with both in the same cycle the slot stays full.
      if (acc_in && win_close) begin
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (acc_in) begin
        if (win_close) begin
          out_reg <= cand;
          wcnt    <= '0;
          idx     <= last_in_frame ? '0 : idx + LOGLEN'(1);
        end else begin
          acc  <= cand;
          wcnt <= wcnt + LOGLEN'(1);
          idx  <= idx + LOGLEN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_maxpool.sv
// tb_stream_maxpool: directed + randomized checks of stream_maxpool using
// three instances (LEN=5/K=2, LEN=4/K=2, LEN=3/K=1) and per-instance
// expected-output queues filled by a small window-max model.
module tb_stream_maxpool;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [7:0] a_sd, b_sd, c_sd;
  logic              a_sv, b_sv, c_sv;
  logic              a_sr, b_sr, c_sr;
  logic signed [7:0] a_md, b_md, c_md;
  logic              a_mv, b_mv, c_mv;
  logic              a_mr, b_mr, c_mr;
  logic              a_fd, b_fd, c_fd;

  stream_maxpool #(.WIDTH(8), .LEN(5), .K(2), .LOGLEN(3)) u_a (
    .clk(clk), .reset(reset), .s_data_in(a_sd), .s_valid(a_sv), .s_ready(a_sr),
    .m_data_out(a_md), .m_valid(a_mv), .m_ready(a_mr), .frame_done(a_fd));

  stream_maxpool #(.WIDTH(8), .LEN(4), .K(2), .LOGLEN(2)) u_b (
    .clk(clk), .reset(reset), .s_data_in(b_sd), .s_valid(b_sv), .s_ready(b_sr),
    .m_data_out(b_md), .m_valid(b_mv), .m_ready(b_mr), .frame_done(b_fd));

  stream_maxpool #(.WIDTH(8), .LEN(3), .K(1), .LOGLEN(2)) u_c (
    .clk(clk), .reset(reset), .s_data_in(c_sd), .s_valid(c_sv), .s_ready(c_sr),
    .m_data_out(c_md), .m_valid(c_mv), .m_ready(c_mr), .frame_done(c_fd));

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [7:0] qa[$], qb[$], qc[$];
  int a_pop = 0, b_pop = 0, c_pop = 0;
  int a_fdn = 0, b_fdn = 0, c_fdn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Scoreboard: a transfer happens at the next posedge whenever valid&ready
  // are both high at the negedge (inputs only move shortly after posedge).
  always @(negedge clk) begin
    if (!reset) begin
      if (a_mv && a_mr) begin
        if (qa.size() == 0) check("a_unexpected_output", 1, 0);
        else begin check("a_data", 32'(a_md), 32'(qa.pop_front())); a_pop++; end
      end
      if (b_mv && b_mr) begin
        if (b_fd === 1'bx) check("b_fd_unknown", 1, 0);
        if (qb.size() == 0) check("b_unexpected_output", 1, 0);
        else begin check("b_data", 32'(b_md), 32'(qb.pop_front())); b_pop++; end
      end
      if (c_mv && c_mr) begin
        if (qc.size() == 0) check("c_unexpected_output", 1, 0);
        else begin check("c_data", 32'(c_md), 32'(qc.pop_front())); c_pop++; end
      end
      if (a_fd) a_fdn++;
      if (b_fd) b_fdn++;
      if (c_fd) c_fdn++;
    end
  end

  // Reference model: window max over a frame, pushed to the chosen queue.
  task automatic model_frame(input int d, input int v[$], input int len, input int k);
    int m = 0;
    logic signed [7:0] r;
    for (int i = 0; i < len; i++) begin
      if (i % k == 0) m = v[i];
      else if (v[i] > m) m = v[i];
      if ((i % k == k - 1) || (i == len - 1)) begin
        r = 8'(m);
        case (d)
          0: qa.push_back(r);
          1: qb.push_back(r);
          default: qc.push_back(r);
        endcase
      end
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0: return a_sr;
      1: return b_sr;
      default: return c_sr;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic signed [7:0] x);
    case (d)
      0: begin a_sv = v; a_sd = x; end
      1: begin b_sv = v; b_sd = x; end
      default: begin c_sv = v; c_sd = x; end
    endcase
  endtask

  // Present one sample, wait (bounded) until it is accepted, then return
  // 1 time unit after the accepting edge.
  task automatic send(input int d, input logic signed [7:0] x);
    int n = 0;
    set_in(d, 1'b1, x);
    #2;
    while (!rdy(d) && n < 200) begin @(posedge clk); #3; n++; end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    set_in(d, 1'b0, x);
  endtask

  task automatic send_frame(input int d, input int v[$]);
    foreach (v[i]) send(d, 8'(v[i]));
  endtask

  initial begin
    int f1[$], f2[$], fr[$];
    int close_pat[5];
    int fd0, n;
    bit done;

    a_sd = '0; b_sd = '0; c_sd = '0;
    a_sv = 0; b_sv = 0; c_sv = 0;
    a_mr = 1; b_mr = 1; c_mr = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(a_sr), 0);
    check("rst_m_valid", 32'(a_mv), 0);
    check("rst_m_data", 32'(a_md), 0);
    check("rst_frame_done", 32'(a_fd), 0);
    @(posedge clk); #1;
    reset = 0;

    // Basic frame, latency and frame_done on instance a
    f1 = '{3, -1, 7, 2, -4};
    close_pat = '{0, 1, 0, 1, 1};
    model_frame(0, f1, 5, 2);
    for (int i = 0; i < 5; i++) begin
      send(0, 8'(f1[i]));
      @(negedge clk);
      check("basic_m_valid_latency", 32'(a_mv), 32'(close_pat[i]));
      if (i == 4) check("basic_frame_done_pulse", 32'(a_fd), 1);
    end
    @(negedge clk);
    check("basic_frame_done_clear", 32'(a_fd), 0);
    check("basic_output_count", 32'(a_pop), 32'(outlen(5, 2)));

    // Signed extremes on instance b
    f1 = '{-128, -128, 127, -128};
    model_frame(1, f1, 4, 2);
    send_frame(1, f1);
    repeat (3) @(negedge clk);
    check("extreme_output_count", 32'(b_pop), 2);

    // Backpressure on instance a
    f1 = '{10, 20, 5, 6, 1};
    model_frame(0, f1, 5, 2);
    a_mr = 0;
    send(0, 8'(f1[0]));
    send(0, 8'(f1[1]));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid_held", 32'(a_mv), 1);
      check("bp_m_data_held", 32'(a_md), 20);
      check("bp_s_ready_low", 32'(a_sr), 0);
    end
    a_mr = 1;
    for (int i = 2; i < 5; i++) send(0, 8'(f1[i]));
    repeat (3) @(negedge clk);

    // Reset mid-frame, then a fresh frame
    f1 = '{1, 2, 3};
    qa.push_back(8'sd2);
    send_frame(0, f1);
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_m_valid", 32'(a_mv), 0);
    check("midrst_frame_done", 32'(a_fd), 0);
    check("midrst_s_ready", 32'(a_sr), 0);
    @(posedge clk); #1;
    reset = 0;
    f1 = '{1, 2, 3, 4, 5};
    model_frame(0, f1, 5, 2);
    send_frame(0, f1);
    repeat (3) @(negedge clk);
    check("midrst_queue_drained", 32'(qa.size()), 0);

    // Two random frames, random gaps and random m_ready
    fd0 = a_fdn;
    f1.delete(); f2.delete();
    for (int i = 0; i < 5; i++) f1.push_back(int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 5; i++) f2.push_back(int'($urandom_range(0, 255)) - 128);
    model_frame(0, f1, 5, 2);
    model_frame(0, f2, 5, 2);
    fr = {f1, f2};
    done = 0;
    fork
      begin
        foreach (fr[i]) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(0, 8'(fr[i]));
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; a_mr = 1'($urandom_range(0, 1)); end
      end
    join
    a_mr = 1;
    n = 0;
    while (qa.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("rand_drained_in_time", 32'(n < 50), 1);
    repeat (2) @(negedge clk);
    check("rand_frame_done_count", 32'(a_fdn - fd0), 2);

    // K=1 pass-through on instance c
    f1 = '{9, -9, 0};
    model_frame(2, f1, 3, 1);
    for (int i = 0; i < 3; i++) begin
      send(2, 8'(f1[i]));
      @(negedge clk);
      check("k1_m_valid_each", 32'(c_mv), 1);
    end
    repeat (2) @(negedge clk);

    check("a_queue_empty", 32'(qa.size()), 0);
    check("b_queue_empty", 32'(qb.size()), 0);
    check("c_queue_empty", 32'(qc.size()), 0);
    check("b_frame_done_count", 32'(b_fdn), 1);
    check("c_frame_done_count", 32'(c_fdn), 1);
    check("c_output_count", 32'(c_pop), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_maxpool.md
# stream_maxpool

Downstream stage of the 1-D convolution layer. Consumes the layer's output vector as a valid/ready stream of signed WIDTH-bit samples, one frame of LEN samples per input vector. Emits the signed maximum of each non-overlapping window of K consecutive samples, so each frame produces ceil(LEN/K) outputs. The output goes out on a registered valid/ready stream to the next layer, with a one-cycle pulse marking the end of each frame.

## Interface
Parameters:
- WIDTH, 8, sample width (signed two's complement), equal to the conv layer WIDTH
- LEN, 5, samples per input frame (conv output length N-M+1)
- K, 2, pooling window size; legal range 1..LEN
- LOGLEN, 3, counter width; must satisfy 2**LOGLEN >= LEN

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_data_in  in  WIDTH  signed input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample this cycle
- m_data_out  out  WIDTH  signed pooled maximum
- m_valid  out  1  m_data_out holds an unconsumed result
- m_ready  in  1  downstream accepts m_data_out
- frame_done  out  1  one-cycle pulse after the last output of a frame is loaded

## Operation
- Input accept: acc_in = s_valid && s_ready.
- s_ready = !reset && (!m_valid || m_ready).
  - Combinational from registered state.
  - Full throughput of one sample per cycle while m_ready is held high.
- Registers:
  - acc (WIDTH): running window maximum
  - wcnt (0..K-1): position within the window
  - idx (0..LEN-1): position within the frame
  - out_reg / m_valid: the output slot
  - frame_done
- Window-max value on an accept: cand = x when wcnt==0, otherwise max(acc, x). The comparison is signed.
- Window closes on an accept when wcnt==K-1 or idx==LEN-1.
- On an accept where the window does not close:
  - acc <= cand
  - wcnt <= wcnt+1
  - idx <= idx+1
- On an accept where the window closes:
  - out_reg <= cand
  - m_valid <= 1
  - wcnt <= 0
  - idx <= (idx==LEN-1) ? 0 : idx+1
- Partial final window (LEN mod K != 0): closes at idx==LEN-1 and emits the max of the samples it holds. No padding is inserted.
- Output drain: m_valid && m_ready with no simultaneous load gives m_valid <= 0. out_reg holds its value.
- Simultaneous drain and load: out_reg takes the new cand and m_valid stays 1. No bubble, no loss.
- frame_done <= 1 for exactly the cycle after an accept with idx==LEN-1, otherwise 0.
- No arithmetic beyond signed compare. Output values equal input values, so no saturation is required.
- Frames run back-to-back. A new frame's first sample may be accepted in the cycle right after the previous frame's last sample.

## Timing
- Reset values (reset high at a clock edge):
  - m_valid = 0, m_data_out = 0, frame_done = 0
  - acc = 0, wcnt = 0, idx = 0
  - s_ready = 0 while reset is asserted
- Latency: the sample that closes a window is accepted at edge t; m_valid = 1 with the result after edge t.
- m_data_out is stable and m_valid stays high until the cycle m_ready is sampled high. This is the standard valid/ready hold rule.
- Backpressure: when m_valid=1 and m_ready=0, s_ready=0 regardless of wcnt. Partial window state is held unchanged.
- Reset mid-frame: the partial window and any pending output are discarded. The next accepted sample is idx 0 of a fresh frame.
- K==1: every accepted sample is forwarded with one-cycle latency.
- K==LEN: one output per frame.

## Structure
- Shared package pool_pkg:
  - signed max function smax(a,b) parameterized on WIDTH (reusable by later pooling variants)
  - constant function outlen(LEN,K) = (LEN+K-1)/K
- Single module, no sub-modules. The output slot is a plain register, not a separate skid-buffer module.
- The testbench drives it either standalone or chained after the generated conv top, with m_data_out → s_data_in, m_valid → s_valid, m_ready ← s_ready.

## Test plan
- LEN=5, K=2, m_ready=1, input 3,-1,7,2,-4 back-to-back → outputs 3,7,-4, each 1 cycle after its closing sample; frame_done pulses once after -4.
- LEN=4, K=2, input -128,-128,127,-128 → outputs -128,127; checks signed compare at both extremes.
- Backpressure: hold m_ready=0 for 5 cycles after the first output → m_valid stays 1 and m_data_out stays constant, s_ready=0. Release m_ready → the stream resumes with no lost or duplicated outputs.
- Assert reset after 3 of 5 samples → m_valid=0, frame_done=0, s_ready=0 during reset. A following full frame 1,2,3,4,5 → outputs 2,4,5.
- Two frames back-to-back with random s_valid gaps and random m_ready → outputs match the reference model; frame_done pulses exactly twice.
- K=1, LEN=3, input 9,-9,0 → outputs 9,-9,0 at one per cycle with m_ready=1.
